// File: rtl/iob_cache_line_fill_buffer_if.sv
// Signal bundle between the cache controller, the read channel and the data memory
// for the miss-fill stage. master = fill buffer side, slave = surrounding logic.
interface iob_cache_line_fill_buffer_if #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned BE_DATA_W     = 64,
    parameter int unsigned WORD_OFFSET_W = 3
) ();
    localparam int unsigned BE_NBYTES_W = $clog2(BE_DATA_W / 8);
    localparam int unsigned BE_RATIO_W  = $clog2(BE_DATA_W / DATA_W);
    localparam int unsigned LINE2BE_W   = WORD_OFFSET_W - BE_RATIO_W;
    localparam int unsigned MISS_ADDR_W = ADDR_W - $clog2(DATA_W / 8);
    localparam int unsigned LINE_ADDR_W = ADDR_W - BE_NBYTES_W - LINE2BE_W;
    localparam int unsigned RADDR_W     = (LINE2BE_W > 0) ? LINE2BE_W : 1;
    localparam int unsigned LINE_W      = BE_DATA_W * (2 ** LINE2BE_W);

    logic                   miss_valid;
    logic [MISS_ADDR_W-1:0] miss_addr;
    logic                   miss_ready;
    logic                   replace_valid;
    logic [LINE_ADDR_W-1:0] replace_addr;
    logic                   replace;
    logic                   read_valid;
    logic [RADDR_W-1:0]     read_addr;
    logic [BE_DATA_W-1:0]   read_rdata;
    logic                   crit_valid;
    logic [DATA_W-1:0]      crit_rdata;
    logic                   line_we;
    logic [LINE_ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0]      line_wdata;
    logic                   fill_done;

    modport master (
        input  miss_valid, miss_addr, replace, read_valid, read_addr, read_rdata,
        output miss_ready, replace_valid, replace_addr, crit_valid, crit_rdata,
        output line_we, line_addr, line_wdata, fill_done
    );

    modport slave (
        output miss_valid, miss_addr, replace, read_valid, read_addr, read_rdata,
        input  miss_ready, replace_valid, replace_addr, crit_valid, crit_rdata,
        input  line_we, line_addr, line_wdata, fill_done
    );
endinterface

// File: rtl/iob_cache_line_fill_buffer.sv
// Miss-fill stage: requests a line from the read channel, collects its beats,
// forwards the critical word early and writes the whole line in one cycle.
module iob_cache_line_fill_buffer #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned BE_DATA_W     = 64,
    parameter int unsigned WORD_OFFSET_W = 3
) (
    input logic                          clk_i,
    input logic                          reset_n,
    iob_cache_line_fill_buffer_if.master bus
);
    localparam int unsigned BE_RATIO_W  = $clog2(BE_DATA_W / DATA_W);
    localparam int unsigned LINE2BE_W   = WORD_OFFSET_W - BE_RATIO_W;
    localparam int unsigned MISS_ADDR_W = ADDR_W - $clog2(DATA_W / 8);
    localparam int unsigned RADDR_W     = (LINE2BE_W > 0) ? LINE2BE_W : 1;
    localparam int unsigned LINE_W      = BE_DATA_W * (2 ** LINE2BE_W);

    typedef enum logic [1:0] {StIdle, StReq, StFill, StWrite} state_e;

    state_e                 state_q, state_d;
    logic [MISS_ADDR_W-1:0] addr_q, addr_d;
    logic                   crit_sent_q, crit_sent_d;
    logic                   crit_valid_q, crit_valid_d;
    logic [DATA_W-1:0]      crit_rdata_q, crit_rdata_d;
    logic [LINE_W-1:0]      line_q;

    logic [RADDR_W-1:0]     wr_idx;
    logic                   beat_hit;
    logic [DATA_W-1:0]      crit_word;

    // With a single-beat line every delivered beat is the critical one.
    if (LINE2BE_W > 0) begin : g_multi_beat
        assign wr_idx   = bus.read_addr;
        assign beat_hit = (bus.read_addr == addr_q[BE_RATIO_W +: LINE2BE_W]);
    end else begin : g_single_beat
        assign wr_idx   = '0;
        assign beat_hit = 1'b1;
    end

    if (BE_RATIO_W > 0) begin : g_word_sel
        assign crit_word = bus.read_rdata[addr_q[0 +: BE_RATIO_W] * DATA_W +: DATA_W];
    end else begin : g_word_full
        assign crit_word = bus.read_rdata[DATA_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        crit_sent_d  = crit_sent_q;
        crit_valid_d = 1'b0;
        crit_rdata_d = crit_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.miss_valid) begin
                    addr_d      = bus.miss_addr;
                    crit_sent_d = 1'b0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (bus.replace) state_d = StFill;
            end
            StFill: begin
                // crit_sent suppresses a second pulse when a retry re-delivers the beat
                if (bus.read_valid && beat_hit && !crit_sent_q) begin
                    crit_valid_d = 1'b1;
                    crit_rdata_d = crit_word;
                    crit_sent_d  = 1'b1;
                end
                if (!bus.replace) state_d = StWrite;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            crit_sent_q  <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            crit_sent_q  <= crit_sent_d;
            crit_valid_q <= crit_valid_d;
            crit_rdata_q <= crit_rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == StFill && bus.read_valid) begin
            line_q[wr_idx * BE_DATA_W +: BE_DATA_W] <= bus.read_rdata;
        end
    end

    assign bus.miss_ready    = (state_q == StIdle);
    assign bus.replace_valid = (state_q == StReq);
    assign bus.replace_addr  = addr_q[MISS_ADDR_W-1 : BE_RATIO_W + LINE2BE_W];
    assign bus.line_addr     = addr_q[MISS_ADDR_W-1 : BE_RATIO_W + LINE2BE_W];
    assign bus.line_we       = (state_q == StWrite);
    assign bus.fill_done     = (state_q == StWrite);
    assign bus.line_wdata    = line_q;
    assign bus.crit_valid    = crit_valid_q;
    assign bus.crit_rdata    = crit_rdata_q;
endmodule

// File: tb/tb_iob_cache_line_fill_buffer.sv
// Bench for the miss-fill stage: a 4-beat default instance driven with directed and
// random fills, plus a single-beat instance (32-bit beats, one word per line).
module tb_iob_cache_line_fill_buffer;
    logic clk_i = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk_i = ~clk_i;

    iob_cache_line_fill_buffer_if #(
        .ADDR_W(32), .DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3)
    ) a_if ();
    iob_cache_line_fill_buffer_if #(
        .ADDR_W(32), .DATA_W(32), .BE_DATA_W(32), .WORD_OFFSET_W(0)
    ) b_if ();

    iob_cache_line_fill_buffer #(
        .ADDR_W(32), .DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3)
    ) u_dut_a (
        .clk_i  (clk_i),
        .reset_n(reset_n),
        .bus    (a_if)
    );

    iob_cache_line_fill_buffer #(
        .ADDR_W(32), .DATA_W(32), .BE_DATA_W(32), .WORD_OFFSET_W(0)
    ) u_dut_b (
        .clk_i  (clk_i),
        .reset_n(reset_n),
        .bus    (b_if)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete miss on instance A. Expected values come from the address
    // arithmetic of a 4-beat, 2-words-per-beat line and the list of deliveries.
    task automatic run_a(input logic [29:0] a, input int d, input int rounds,
                         input bit shuffle, input bit merge_last, input bit directed,
                         input bit junk);
        logic [63:0]  exp_beat [4];
        logic [255:0] exp_line;
        logic [63:0]  data;
        logic [31:0]  exp_crit;
        logic [26:0]  exp_la;
        int           order [4];
        int           crit_idx, idx, j, tmp;
        bit           crit_seen, exp_cv, last;

        crit_idx  = int'((a / 30'd2) % 30'd4);
        exp_la    = 27'(a / 30'd8);
        crit_seen = 1'b0;
        exp_crit  = '0;

        check("miss_ready_idle", a_if.miss_ready, 1);
        a_if.miss_valid = 1'b1;
        a_if.miss_addr  = a;
        tick();
        a_if.miss_valid = junk;
        a_if.miss_addr  = 30'($urandom);
        check("req_valid", a_if.replace_valid, 1);
        check("req_addr", a_if.replace_addr, exp_la);
        check("miss_ready_busy", a_if.miss_ready, 0);
        repeat (d) begin
            tick();
            check("req_hold", a_if.replace_valid, 1);
        end
        a_if.replace = 1'b1;
        tick();
        check("req_drop", a_if.replace_valid, 0);

        for (int r = 0; r < rounds; r++) begin
            for (int k = 0; k < 4; k++) order[k] = k;
            if (shuffle) begin
                for (int k = 3; k > 0; k--) begin
                    j        = int'($urandom_range(0, k));
                    tmp      = order[k];
                    order[k] = order[j];
                    order[j] = tmp;
                end
            end
            for (int k = 0; k < 4; k++) begin
                repeat (directed ? 0 : int'($urandom_range(0, 2))) begin
                    tick();
                    check("crit_idle", a_if.crit_valid, 0);
                    check("fill_ready", a_if.miss_ready, 0);
                end
                idx  = order[k];
                data = (directed && r == 0) ? {16{4'(idx + 1)}} : {$urandom, $urandom};
                exp_beat[idx] = data;
                exp_cv = (idx == crit_idx) && !crit_seen;
                if (exp_cv) begin
                    crit_seen = 1'b1;
                    exp_crit  = 32'(data >> (32 * int'(a % 30'd2)));
                end
                last = (r == rounds - 1) && (k == 3);
                a_if.read_valid = 1'b1;
                a_if.read_addr  = 2'(idx);
                a_if.read_rdata = data;
                if (last && merge_last) a_if.replace = 1'b0;
                tick();
                a_if.read_valid = 1'b0;
                a_if.read_addr  = 2'($urandom);
                a_if.read_rdata = {$urandom, $urandom};
                check("crit_valid", a_if.crit_valid, exp_cv);
                if (exp_cv) check("crit_rdata", a_if.crit_rdata, exp_crit);
            end
        end
        if (!merge_last) begin
            a_if.replace = 1'b0;
            tick();
            check("crit_once", a_if.crit_valid, 0);
        end
        a_if.miss_valid = 1'b0;
        for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = exp_beat[k];
        check("line_we", a_if.line_we, 1);
        check("fill_done", a_if.fill_done, 1);
        check("line_wdata", a_if.line_wdata, exp_line);
        check("line_addr", a_if.line_addr, exp_la);
        check("write_ready", a_if.miss_ready, 0);
        tick();
        check("line_we_once", a_if.line_we, 0);
        check("fill_done_once", a_if.fill_done, 0);
        check("ready_back", a_if.miss_ready, 1);
    endtask

    // Single-beat instance: one or two deliveries of the only beat.
    task automatic run_b(input logic [29:0] a, input logic [31:0] d1, input logic [31:0] d2,
                         input bit two);
        check("b_ready_idle", b_if.miss_ready, 1);
        b_if.miss_valid = 1'b1;
        b_if.miss_addr  = a;
        tick();
        b_if.miss_valid = 1'b0;
        check("b_req_valid", b_if.replace_valid, 1);
        check("b_req_addr", b_if.replace_addr, a);
        b_if.replace = 1'b1;
        tick();
        b_if.read_valid = 1'b1;
        b_if.read_addr  = 1'($urandom);
        b_if.read_rdata = d1;
        tick();
        check("b_crit_valid", b_if.crit_valid, 1);
        check("b_crit_rdata", b_if.crit_rdata, d1);
        b_if.read_rdata = d2;
        b_if.read_valid = two;
        tick();
        b_if.read_valid = 1'b0;
        check("b_crit_once", b_if.crit_valid, 0);
        b_if.replace = 1'b0;
        tick();
        check("b_line_we", b_if.line_we, 1);
        check("b_fill_done", b_if.fill_done, 1);
        check("b_line_wdata", b_if.line_wdata, two ? d2 : d1);
        check("b_line_addr", b_if.line_addr, a);
        tick();
        check("b_ready_back", b_if.miss_ready, 1);
        check("b_line_we_once", b_if.line_we, 0);
    endtask

    initial begin
        a_if.miss_valid = 1'b0; a_if.miss_addr = '0; a_if.replace = 1'b0;
        a_if.read_valid = 1'b0; a_if.read_addr = '0; a_if.read_rdata = '0;
        b_if.miss_valid = 1'b0; b_if.miss_addr = '0; b_if.replace = 1'b0;
        b_if.read_valid = 1'b0; b_if.read_addr = '0; b_if.read_rdata = '0;

        #3;
        check("rst_replace_valid", a_if.replace_valid, 0);
        check("rst_crit_valid", a_if.crit_valid, 0);
        check("rst_line_we", a_if.line_we, 0);
        check("rst_fill_done", a_if.fill_done, 0);
        check("rst_miss_ready", a_if.miss_ready, 1);
        check("rst_replace_addr", a_if.replace_addr, 0);
        check("rst_b_line_we", b_if.line_we, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Directed fill from the plan: word 0x105, beats in order.
        run_a(30'h0000_0105, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Read channel slow to accept: request held for 5 cycles.
        run_a(30'h0000_0105, 5, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Retry: second delivery must win in the line, crit from the first.
        run_a(30'h0000_0105, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        // Misses presented during the fill must be ignored.
        run_a(30'h1234_5678, 2, 1, 1'b1, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 16; n++) begin
            run_a(30'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(1, 2)),
                  1'b1, 1'($urandom), 1'b0, 1'($urandom));
        end

        // Reset in the middle of a fill, right after the critical beat.
        a_if.miss_valid = 1'b1;
        a_if.miss_addr  = 30'h0000_0402;
        tick();
        a_if.miss_valid = 1'b0;
        a_if.replace    = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            a_if.read_valid = 1'b1;
            a_if.read_addr  = 2'(k);
            a_if.read_rdata = {$urandom, $urandom};
            tick();
        end
        a_if.read_valid = 1'b0;
        check("pre_rst_crit", a_if.crit_valid, 1);
        check("pre_rst_busy", a_if.miss_ready, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_crit_valid", a_if.crit_valid, 0);
        check("async_miss_ready", a_if.miss_ready, 1);
        check("async_line_we", a_if.line_we, 0);
        check("async_fill_done", a_if.fill_done, 0);
        a_if.replace = 1'b0;
        repeat (2) begin
            tick();
            check("rst_no_line_we", a_if.line_we, 0);
        end
        reset_n = 1'b1;
        tick();
        check("post_rst_no_line_we", a_if.line_we, 0);
        check("post_rst_ready", a_if.miss_ready, 1);
        run_a(30'h0000_0402, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        run_b(30'h0000_0007, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_b(30'($urandom), $urandom, $urandom, 1'b1);
        run_b(30'($urandom), $urandom, $urandom, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
